// File: rtl/csr_exc_ctrl_pkg.sv
// Shared definitions for the WB-to-CSR exception/ertn commit controller:
// exception codes, exception-vector bit positions and FSM encodings.
package csr_exc_ctrl_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam logic [8:0] ESUBCODE_NONE = 9'h000;

    localparam int EXC_W        = 5;
    localparam int EXC_ADEF_BIT = 0;
    localparam int EXC_ALE_BIT  = 1;
    localparam int EXC_SYS_BIT  = 2;
    localparam int EXC_BRK_BIT  = 3;
    localparam int EXC_INE_BIT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_EX_COMMIT   = 2'd1,
        ST_ERTN_COMMIT = 2'd2,
        ST_REDIRECT    = 2'd3
    } state_e;

    typedef enum logic {
        KIND_EX   = 1'b0,
        KIND_ERTN = 1'b1
    } kind_e;

endpackage

// File: rtl/csr_exc_ctrl_if.sv
// Bundle of WB-stage, CSR-file and pre-IF signals around the commit controller.
// slave = controller side, master = surrounding pipeline / CSR file side.
interface csr_exc_ctrl_if #(
    parameter int PC_W      = 32,
    parameter int CSR_NUM_W = 14
);
    logic                 wb_valid;
    logic                 wb_ready;
    logic [PC_W-1:0]      wb_pc;
    logic [4:0]           wb_exc;
    logic                 wb_ertn;
    logic                 wb_csr_we;
    logic [CSR_NUM_W-1:0] wb_csr_num;
    logic [31:0]          wb_csr_wmask;
    logic [31:0]          wb_csr_wvalue;
    logic                 has_int;

    logic                 csr_we;
    logic [CSR_NUM_W-1:0] csr_num;
    logic [31:0]          csr_wmask;
    logic [31:0]          csr_wvalue;
    logic                 csr_wb_ex;
    logic [5:0]           csr_ecode;
    logic [8:0]           csr_esubcode;
    logic [PC_W-1:0]      csr_era_pc;
    logic                 csr_ertn_flush;
    logic [PC_W-1:0]      ex_entry;
    logic [PC_W-1:0]      ertn_entry;

    logic                 flush;
    logic                 redirect_valid;
    logic [PC_W-1:0]      redirect_pc;
    logic                 redirect_ready;

    modport slave (
        input  wb_valid, wb_pc, wb_exc, wb_ertn, wb_csr_we, wb_csr_num,
               wb_csr_wmask, wb_csr_wvalue, has_int, ex_entry, ertn_entry,
               redirect_ready,
        output wb_ready, csr_we, csr_num, csr_wmask, csr_wvalue, csr_wb_ex,
               csr_ecode, csr_esubcode, csr_era_pc, csr_ertn_flush, flush,
               redirect_valid, redirect_pc
    );

    modport master (
        output wb_valid, wb_pc, wb_exc, wb_ertn, wb_csr_we, wb_csr_num,
               wb_csr_wmask, wb_csr_wvalue, has_int, ex_entry, ertn_entry,
               redirect_ready,
        input  wb_ready, csr_we, csr_num, csr_wmask, csr_wvalue, csr_wb_ex,
               csr_ecode, csr_esubcode, csr_era_pc, csr_ertn_flush, flush,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/csr_exc_ctrl_exc_prio_enc.sv
// Combinational exception-cause priority encoder. Interrupt outranks every
// synchronous cause; shared with ID-stage interrupt tagging.
import csr_exc_ctrl_pkg::*;

module exc_prio_enc (
    input  logic             has_int,
    input  logic [EXC_W-1:0] exc,
    output logic             any_exc,
    output logic [5:0]       ecode,
    output logic [8:0]       esubcode
);

    // Highest-priority cause selection
    always_comb begin
        any_exc  = 1'b1;
        ecode    = ECODE_INT;
        esubcode = ESUBCODE_NONE;
        if (has_int) begin
            ecode = ECODE_INT;
        end else if (exc[EXC_ADEF_BIT]) begin
            ecode = ECODE_ADEF;
        end else if (exc[EXC_ALE_BIT]) begin
            ecode = ECODE_ALE;
        end else if (exc[EXC_SYS_BIT]) begin
            ecode = ECODE_SYS;
        end else if (exc[EXC_BRK_BIT]) begin
            ecode = ECODE_BRK;
        end else if (exc[EXC_INE_BIT]) begin
            ecode = ECODE_INE;
        end else begin
            any_exc = 1'b0;
            ecode   = ECODE_INT;
        end
    end

endmodule

// File: rtl/csr_exc_ctrl.sv
// WB-stage exception / interrupt / ertn commit sequencer: pulses the CSR file,
// then holds flush and a redirect to pre-IF until the redirect is accepted.
import csr_exc_ctrl_pkg::*;

module csr_exc_ctrl #(
    parameter int PC_W      = 32,
    parameter int CSR_NUM_W = 14
) (
    input  logic           clk,
    input  logic           resetn,
    csr_exc_ctrl_if.slave  bus
);

    state_e          state_r;
    state_e          state_nxt_s;
    kind_e           kind_r;
    kind_e           kind_nxt_s;
    logic [5:0]      ecode_r;
    logic [8:0]      esubcode_r;
    logic [PC_W-1:0] pc_r;

    logic            any_exc_s;
    logic [5:0]      ecode_s;
    logic [8:0]      esubcode_s;
    logic            accept_s;
    logic            latch_exc_s;

    logic                 wb_ready_s;
    logic                 csr_we_s;
    logic [CSR_NUM_W-1:0] csr_num_s;
    logic [31:0]          csr_wmask_s;
    logic [31:0]          csr_wvalue_s;
    logic                 csr_wb_ex_s;
    logic [5:0]           csr_ecode_s;
    logic [8:0]           csr_esubcode_s;
    logic [PC_W-1:0]      csr_era_pc_s;
    logic                 csr_ertn_flush_s;
    logic                 flush_s;
    logic                 redirect_valid_s;
    logic [PC_W-1:0]      redirect_pc_s;

    exc_prio_enc u_exc_prio_enc (
        .has_int  (bus.has_int),
        .exc      (bus.wb_exc),
        .any_exc  (any_exc_s),
        .ecode    (ecode_s),
        .esubcode (esubcode_s)
    );

    // Handshake: only IDLE takes a new instruction, never while held in reset
    always_comb begin
        wb_ready_s = (state_r == ST_IDLE);
        accept_s   = bus.wb_valid & wb_ready_s & resetn;
    end

    // Next-state and redirect-kind selection
    always_comb begin
        state_nxt_s = state_r;
        kind_nxt_s  = kind_r;
        latch_exc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && any_exc_s) begin
                    state_nxt_s = ST_EX_COMMIT;
                    latch_exc_s = 1'b1;
                end else if (accept_s && bus.wb_ertn) begin
                    state_nxt_s = ST_ERTN_COMMIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EX_COMMIT: begin
                state_nxt_s = ST_REDIRECT;
                kind_nxt_s  = KIND_EX;
            end
            ST_ERTN_COMMIT: begin
                state_nxt_s = ST_REDIRECT;
                kind_nxt_s  = KIND_ERTN;
            end
            ST_REDIRECT: begin
                if (bus.redirect_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REDIRECT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode; plain CSR writes bypass the FSM with zero added latency
    always_comb begin
        csr_we_s         = accept_s & bus.wb_csr_we & ~any_exc_s & ~bus.wb_ertn;
        csr_num_s        = {CSR_NUM_W{1'b0}};
        csr_wmask_s      = 32'h0000_0000;
        csr_wvalue_s     = 32'h0000_0000;
        csr_wb_ex_s      = 1'b0;
        csr_ecode_s      = 6'h00;
        csr_esubcode_s   = 9'h000;
        csr_era_pc_s     = {PC_W{1'b0}};
        csr_ertn_flush_s = 1'b0;
        flush_s          = 1'b0;
        redirect_valid_s = 1'b0;
        redirect_pc_s    = {PC_W{1'b0}};
        if (csr_we_s) begin
            csr_num_s    = bus.wb_csr_num;
            csr_wmask_s  = bus.wb_csr_wmask;
            csr_wvalue_s = bus.wb_csr_wvalue;
        end else begin
            csr_num_s    = {CSR_NUM_W{1'b0}};
        end
        case (state_r)
            ST_IDLE: begin
                flush_s = 1'b0;
            end
            ST_EX_COMMIT: begin
                csr_wb_ex_s    = 1'b1;
                csr_ecode_s    = ecode_r;
                csr_esubcode_s = esubcode_r;
                csr_era_pc_s   = pc_r;
                flush_s        = 1'b1;
            end
            ST_ERTN_COMMIT: begin
                csr_ertn_flush_s = 1'b1;
                flush_s          = 1'b1;
            end
            ST_REDIRECT: begin
                flush_s          = 1'b1;
                redirect_valid_s = 1'b1;
                // CSR file already reflects the commit, so entries are read live
                if (kind_r == KIND_ERTN) begin
                    redirect_pc_s = bus.ertn_entry;
                end else begin
                    redirect_pc_s = bus.ex_entry;
                end
            end
            default: begin
                flush_s = 1'b0;
            end
        endcase
    end

    // State, redirect kind and latched exception context
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            kind_r     <= KIND_EX;
            ecode_r    <= 6'h00;
            esubcode_r <= 9'h000;
            pc_r       <= {PC_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            kind_r  <= kind_nxt_s;
            if (latch_exc_s) begin
                ecode_r    <= ecode_s;
                esubcode_r <= esubcode_s;
                pc_r       <= bus.wb_pc;
            end
        end
    end

    assign bus.wb_ready       = wb_ready_s;
    assign bus.csr_we         = csr_we_s;
    assign bus.csr_num        = csr_num_s;
    assign bus.csr_wmask      = csr_wmask_s;
    assign bus.csr_wvalue     = csr_wvalue_s;
    assign bus.csr_wb_ex      = csr_wb_ex_s;
    assign bus.csr_ecode      = csr_ecode_s;
    assign bus.csr_esubcode   = csr_esubcode_s;
    assign bus.csr_era_pc     = csr_era_pc_s;
    assign bus.csr_ertn_flush = csr_ertn_flush_s;
    assign bus.flush          = flush_s;
    assign bus.redirect_valid = redirect_valid_s;
    assign bus.redirect_pc    = redirect_pc_s;

endmodule

// File: tb/tb_csr_exc_ctrl.sv
// Self-checking bench for csr_exc_ctrl: expected commit pulses are queued when
// an instruction is driven and popped by a monitor when the CSR pulse appears.
module tb_csr_exc_ctrl;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    typedef struct {
        logic        is_ex;
        logic [5:0]  ecode;
        logic [31:0] era;
    } exp_t;
    exp_t exp_q[$];

    csr_exc_ctrl_if #(.PC_W(32), .CSR_NUM_W(14)) bus ();

    csr_exc_ctrl #(.PC_W(32), .CSR_NUM_W(14)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every CSR commit pulse must match the queue head
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (bus.csr_wb_ex === 1'b1 || bus.csr_ertn_flush === 1'b1) begin
                checks++;
                if (bus.csr_wb_ex === 1'b1 && bus.csr_ertn_flush === 1'b1) begin
                    errors++;
                    $display("FAIL pulse_overlap: wb_ex=1 ertn_flush=1, required never both");
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: wb_ex=%0b ertn_flush=%0b, required none",
                             bus.csr_wb_ex, bus.csr_ertn_flush);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus.csr_wb_ex !== e.is_ex || bus.csr_ertn_flush !== !e.is_ex) begin
                        errors++;
                        $display("FAIL commit_kind: wb_ex=%0b ertn_flush=%0b, required wb_ex=%0b",
                                 bus.csr_wb_ex, bus.csr_ertn_flush, e.is_ex);
                    end else if (e.is_ex && (bus.csr_ecode !== e.ecode || bus.csr_era_pc !== e.era
                                 || bus.csr_esubcode !== 9'h000)) begin
                        errors++;
                        $display("FAIL commit_ctx: ecode=%h era=%h esub=%h, required ecode=%h era=%h esub=000",
                                 bus.csr_ecode, bus.csr_era_pc, bus.csr_esubcode, e.ecode, e.era);
                    end
                end
            end
        end
    end

    task automatic clear_wb();
        bus.wb_valid      = 1'b0;
        bus.wb_pc         = 32'h0;
        bus.wb_exc        = 5'b00000;
        bus.wb_ertn       = 1'b0;
        bus.wb_csr_we     = 1'b0;
        bus.wb_csr_num    = 14'h0;
        bus.wb_csr_wmask  = 32'h0;
        bus.wb_csr_wvalue = 32'h0;
        bus.has_int       = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn             = 1'b0;
        clear_wb();
        bus.ex_entry       = 32'h0;
        bus.ertn_entry     = 32'h0;
        bus.redirect_ready = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if (bus.wb_ready !== 1'b1 || bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0
            || bus.csr_we !== 1'b0 || bus.csr_wb_ex !== 1'b0 || bus.csr_ertn_flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%0b flush=%0b rv=%0b we=%0b wbex=%0b ertn=%0b, required 1 0 0 0 0 0",
                     bus.wb_ready, bus.flush, bus.redirect_valid, bus.csr_we, bus.csr_wb_ex, bus.csr_ertn_flush);
        end
        next_cycle();
        resetn = 1'b1;
        next_cycle();
    endtask

    task automatic test_csrwr();
        bus.wb_valid      = 1'b1;
        bus.wb_csr_we     = 1'b1;
        bus.wb_csr_num    = 14'h0030;
        bus.wb_csr_wmask  = 32'hFFFF_FFFF;
        bus.wb_csr_wvalue = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (bus.csr_we !== 1'b1 || bus.csr_num !== 14'h0030 || bus.csr_wmask !== 32'hFFFF_FFFF
            || bus.csr_wvalue !== 32'hDEAD_BEEF || bus.wb_ready !== 1'b1 || bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL csrwr_1: we=%0b num=%h mask=%h val=%h ready=%0b flush=%0b, required 1 0030 ffffffff deadbeef 1 0",
                     bus.csr_we, bus.csr_num, bus.csr_wmask, bus.csr_wvalue, bus.wb_ready, bus.flush);
        end
        next_cycle();
        bus.wb_csr_num    = 14'h0031;
        bus.wb_csr_wmask  = 32'h0000_FFFF;
        bus.wb_csr_wvalue = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (bus.csr_we !== 1'b1 || bus.csr_num !== 14'h0031 || bus.csr_wmask !== 32'h0000_FFFF
            || bus.csr_wvalue !== 32'h1234_5678 || bus.wb_ready !== 1'b1 || bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL csrwr_back_to_back: we=%0b num=%h mask=%h val=%h ready=%0b flush=%0b, required 1 0031 0000ffff 12345678 1 0",
                     bus.csr_we, bus.csr_num, bus.csr_wmask, bus.csr_wvalue, bus.wb_ready, bus.flush);
        end
        next_cycle();
        bus.wb_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.csr_we !== 1'b0 || bus.flush !== 1'b0 || bus.wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL csrwr_idle: we=%0b flush=%0b ready=%0b, required 0 0 1",
                     bus.csr_we, bus.flush, bus.wb_ready);
        end
        clear_wb();
        next_cycle();
    endtask

    // Full exception sequence with redirect_ready raised in the first redirect cycle
    task automatic test_exception(input string name, input logic has_int, input logic [4:0] exc,
                                  input logic ertn, input logic csr_we, input logic [31:0] pc,
                                  input logic [31:0] entry, input logic [5:0] exp_ecode);
        exp_t e;
        e.is_ex = 1'b1;
        e.ecode = exp_ecode;
        e.era   = pc;
        exp_q.push_back(e);
        bus.ex_entry      = entry;
        bus.ertn_entry    = ~entry;
        bus.wb_valid      = 1'b1;
        bus.wb_pc         = pc;
        bus.wb_exc        = exc;
        bus.has_int       = has_int;
        bus.wb_ertn       = ertn;
        bus.wb_csr_we     = csr_we;
        bus.wb_csr_num    = 14'h0006;
        bus.wb_csr_wmask  = 32'hFFFF_FFFF;
        bus.wb_csr_wvalue = 32'hA5A5_A5A5;
        @(negedge clk);
        checks++;
        if (bus.wb_ready !== 1'b1 || bus.csr_we !== 1'b0 || bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: ready=%0b we=%0b flush=%0b, required 1 0 0",
                     name, bus.wb_ready, bus.csr_we, bus.flush);
        end
        next_cycle();
        clear_wb();
        @(negedge clk);
        checks++;
        if (bus.csr_wb_ex !== 1'b1 || bus.flush !== 1'b1 || bus.redirect_valid !== 1'b0
            || bus.wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_commit: wbex=%0b flush=%0b rv=%0b ready=%0b, required 1 1 0 0",
                     name, bus.csr_wb_ex, bus.flush, bus.redirect_valid, bus.wb_ready);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== entry || bus.flush !== 1'b1
            || bus.csr_wb_ex !== 1'b0) begin
            errors++;
            $display("FAIL %s_redirect: rv=%0b pc=%h flush=%0b wbex=%0b, required 1 %h 1 0",
                     name, bus.redirect_valid, bus.redirect_pc, bus.flush, bus.csr_wb_ex, entry);
        end
        bus.redirect_ready = 1'b1;
        next_cycle();
        bus.redirect_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wb_ready !== 1'b1 || bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_return: ready=%0b flush=%0b rv=%0b, required 1 0 0",
                     name, bus.wb_ready, bus.flush, bus.redirect_valid);
        end
        next_cycle();
    endtask

    task automatic test_int_without_instr();
        bus.has_int = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.flush !== 1'b0 || bus.wb_ready !== 1'b1 || bus.csr_wb_ex !== 1'b0) begin
                errors++;
                $display("FAIL int_idle_%0d: flush=%0b ready=%0b wbex=%0b, required 0 1 0",
                         i, bus.flush, bus.wb_ready, bus.csr_wb_ex);
            end
            next_cycle();
        end
        bus.has_int = 1'b0;
    endtask

    task automatic test_ertn_backpressure();
        exp_t e;
        int   pulses;
        e.is_ex = 1'b0;
        e.ecode = 6'h00;
        e.era   = 32'h0;
        exp_q.push_back(e);
        pulses             = 0;
        bus.ertn_entry     = 32'h1C00_0104;
        bus.ex_entry       = 32'h1C00_8000;
        bus.redirect_ready = 1'b0;
        bus.wb_valid       = 1'b1;
        bus.wb_ertn        = 1'b1;
        bus.wb_pc          = 32'h1C00_0200;
        next_cycle();
        clear_wb();
        @(negedge clk);
        if (bus.csr_ertn_flush === 1'b1) pulses++;
        checks++;
        if (bus.flush !== 1'b1 || bus.wb_ready !== 1'b0 || bus.csr_wb_ex !== 1'b0) begin
            errors++;
            $display("FAIL ertn_commit: flush=%0b ready=%0b wbex=%0b, required 1 0 0",
                     bus.flush, bus.wb_ready, bus.csr_wb_ex);
        end
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) bus.ex_entry = 32'h0BAD_0BAD;
            @(negedge clk);
            if (bus.csr_ertn_flush === 1'b1) pulses++;
            checks++;
            if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h1C00_0104
                || bus.wb_ready !== 1'b0 || bus.flush !== 1'b1) begin
                errors++;
                $display("FAIL ertn_hold_%0d: rv=%0b pc=%h ready=%0b flush=%0b, required 1 1c000104 0 1",
                         i, bus.redirect_valid, bus.redirect_pc, bus.wb_ready, bus.flush);
            end
            next_cycle();
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ertn_pulse_width: cycles=%0d, required 1", pulses);
        end
        bus.redirect_ready = 1'b1;
        next_cycle();
        bus.redirect_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wb_ready !== 1'b1 || bus.redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL ertn_return: ready=%0b rv=%0b, required 1 0", bus.wb_ready, bus.redirect_valid);
        end
        next_cycle();
    endtask

    task automatic test_reset_in_redirect();
        exp_t e;
        e.is_ex = 1'b1;
        e.ecode = 6'h0B;
        e.era   = 32'h1C00_0300;
        exp_q.push_back(e);
        bus.ex_entry       = 32'h1C00_9000;
        bus.redirect_ready = 1'b0;
        bus.wb_valid       = 1'b1;
        bus.wb_exc         = 5'b00100;
        bus.wb_pc          = 32'h1C00_0300;
        next_cycle();
        clear_wb();
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h1C00_9000) begin
            errors++;
            $display("FAIL rst_redirect_pre: rv=%0b pc=%h, required 1 1c009000",
                     bus.redirect_valid, bus.redirect_pc);
        end
        resetn = 1'b0;
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0 || bus.wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_redirect_post: rv=%0b flush=%0b ready=%0b, required 0 0 1",
                     bus.redirect_valid, bus.flush, bus.wb_ready);
        end
        next_cycle();
        test_exception("sys_after_rst", 1'b0, 5'b00100, 1'b0, 1'b0,
                       32'h1C00_0400, 32'h1C00_8000, 6'h0B);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_csrwr();
        test_exception("syscall",  1'b0, 5'b00100, 1'b0, 1'b0, 32'h1C00_0100, 32'h1C00_8000, 6'h0B);
        test_exception("prio_int", 1'b1, 5'b11111, 1'b0, 1'b0, 32'h1C00_0110, 32'h1C00_8040, 6'h00);
        test_exception("prio_adef",1'b0, 5'b11111, 1'b0, 1'b0, 32'h1C00_0120, 32'h1C00_8080, 6'h08);
        test_exception("prio_ine", 1'b0, 5'b10000, 1'b0, 1'b0, 32'h1C00_0130, 32'h1C00_80C0, 6'h0D);
        test_exception("prio_brk", 1'b0, 5'b11000, 1'b0, 1'b0, 32'h1C00_0140, 32'h1C00_8100, 6'h0C);
        test_exception("ale_ertn_we", 1'b0, 5'b00010, 1'b1, 1'b1, 32'h1C00_0150, 32'h1C00_8140, 6'h09);
        test_int_without_instr();
        test_ertn_backpressure();
        test_reset_in_redirect();
        repeat (3) next_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
